instruction_memory_responder: RTL and testbench
===============================================

// Module: instruction_memory_responder
// PURPOSE
//  Responder end of the instruction-fetch syn/ack/last protocol. It accepts a
//  burst request (syn + start byte address) from the fetch stage and streams
//  instruction words from an internal word array, one ack pulse per word.
//  It raises last on the final word of the burst. A write port loads the program.
// PARAMETERS
//  IWIDTH     32            instruction/data word width
//  AWIDTH     32            byte-address width
//  DEPTH      1024          array depth in words (power of 2, >=2)
//  BURST_LEN  8             max words per burst (>=1)
//  LATENCY    1             wait cycles before each word's ack (0..15)
//  NOP        32'h00000013  word returned for out-of-range addresses
// PORTS
//  im_clk      in   1       clock, rising edge
//  im_rst      in   1       asynchronous reset, active-low
//  im_i_syn    in   1       request from fetch; high = keep streaming
//  im_i_addr   in   AWIDTH  burst start byte address, sampled at burst start
//  im_o_ack    out  1       one-cycle pulse: im_o_instr valid
//  im_o_last   out  1       high with ack on final word of burst
//  im_o_instr  out  IWIDTH  returned word; held until next ack
//  im_o_err    out  1       high with ack when word address >= DEPTH
//  im_o_busy   out  1       high while a burst is active (not IDLE)
//  im_i_we     in   1       program-load write enable
//  im_i_waddr  in   AWIDTH  write byte address (word index = [..:2])
//  im_i_wdata  in   IWIDTH  write data
// BEHAVIOUR
//  Reset (im_rst=0, async): all outputs 0; state=IDLE; counters 0.
//   The array is not cleared.
//  Word index = addr >> 2. Bits [1:0] are ignored.
//   Internal address advances by 4 per word, in AWIDTH-bit arithmetic
//   with wraparound.
//  FSM: IDLE, WAIT, RESP, DONE.
//   IDLE: when syn=1, capture im_i_addr and set beat=0.
//         Go to WAIT if LATENCY>0, else RESP.
//   WAIT: count LATENCY cycles, then go to RESP.
//         If syn=0, go to IDLE; no ack is issued.
//   RESP: ack=1 for exactly 1 cycle and instr <= mem[idx].
//         If idx>=DEPTH: instr <= NOP and err=1.
//         last=1 if beat==BURST_LEN-1 or idx==DEPTH-1.
//         Next state: if last -> DONE;
//         else if syn=1 -> beat++, addr+=4, go to WAIT (or RESP if LATENCY=0);
//         else -> IDLE.
//   DONE: no acks. Go to IDLE once syn=0, so a new burst needs a syn low->high.
//  Latency: with syn high in IDLE at cycle N, the first ack is at N+1+LATENCY.
//   Subsequent words follow every LATENCY+1 cycles.
//   With LATENCY=0, ack is high back-to-back every cycle.
//  ack, last and err are registered and are low in every non-RESP cycle.
//   im_o_instr is held until the next ack, because the fetch stage samples
//   it one cycle after ack.
//  syn drop mid-burst (flush): any word not yet acked is discarded; no late ack.
//   The ack in the drop cycle itself still completes.
//  Writes occur in any state on a rising edge with we=1.
//   Out-of-range writes are ignored.
//   A read and a write to the same index in the same cycle returns old data
//   (read-first); the new data is visible from the next read.
//  Reset asserted mid-burst: immediate return to IDLE; ack/last drop at once.
// TESTING
//  T1 load mem[0..7]=0x100+i, LATENCY=1, syn=1 addr=0 held
//     -> 8 acks 2 cycles apart, instr 0x100..0x107, last only on 8th, then DONE.
//  T2 LATENCY=0, addr=0x10, syn held
//     -> acks on consecutive cycles returning mem[4..11]; last on the 8th beat.
//  T3 addr=(DEPTH-2)*4
//     -> 2 acks, last on the word at DEPTH-1 (burst truncated), err=0.
//  T4 addr=DEPTH*4 -> ack with instr=0x00000013, err=1.
//  T5 syn dropped during WAIT of beat 3
//     -> no further ack, busy=0 the next cycle.
//     Re-raised syn with addr=0x20 -> fresh burst starting at mem[8].
//  T6 reset pulse during RESP -> ack/last/busy=0 immediately.
//     Write to the index being read -> old value returned, new value on re-read.

Source files
------------

// File: rtl/instruction_memory_responder.sv
// Responder end of the instruction-fetch syn/ack/last protocol.
// Accepts a burst request (syn + start byte address) and streams words from an
// internal array, one registered ack pulse per word, with last on the final word.
// A write port loads the program; reads and writes at the same index on the same
// edge are read-first.
//
// Ports:
//   im_clk      clock, rising edge
//   im_rst      asynchronous reset, active-low
//   im_i_syn    request from fetch; high = keep streaming
//   im_i_addr   burst start byte address, sampled at burst start
//   im_o_ack    one-cycle pulse: im_o_instr valid
//   im_o_last   high with ack on the final word of the burst
//   im_o_instr  returned word, held until the next ack
//   im_o_err    high with ack when the word address is >= DEPTH
//   im_o_busy   high while a burst is active
//   im_i_we     program-load write enable
//   im_i_waddr  write byte address (word index = [..:2])
//   im_i_wdata  write data
module instruction_memory_responder #(
    parameter int unsigned      IWIDTH    = 32,
    parameter int unsigned      AWIDTH    = 32,
    parameter int unsigned      DEPTH     = 1024,
    parameter int unsigned      BURST_LEN = 8,
    parameter int unsigned      LATENCY   = 1,
    parameter logic [IWIDTH-1:0] NOP      = IWIDTH'(32'h00000013)
) (
    input  logic              im_clk,
    input  logic              im_rst,
    input  logic              im_i_syn,
    input  logic [AWIDTH-1:0] im_i_addr,
    output logic              im_o_ack,
    output logic              im_o_last,
    output logic [IWIDTH-1:0] im_o_instr,
    output logic              im_o_err,
    output logic              im_o_busy,
    input  logic              im_i_we,
    input  logic [AWIDTH-1:0] im_i_waddr,
    input  logic [IWIDTH-1:0] im_i_wdata
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] LAT_M1 = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // State entered ahead of each word: a wait phase unless latency is zero.
    localparam state_e BEAT_ENTRY = (LATENCY > 0) ? S_WAIT : S_RESP;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              ack_q, last_q, err_q, busy_q;
    logic [IWIDTH-1:0] instr_q;
    logic [IWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] rd_idx_c;
    logic              rd_in_range_c;
    logic              rd_last_c;
    logic              enter_resp_c;
    logic              wr_in_range_c;

    // Next-state logic; the response registers load on the edge entering RESP
    // so ack is visible in the same cycle the FSM sits in RESP.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (im_i_syn) begin
                    addr_d  = im_i_addr;
                    beat_d  = '0;
                    wcnt_d  = '0;
                    state_d = BEAT_ENTRY;
                end
            end
            S_WAIT: begin
                if (!im_i_syn) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == LAT_M1) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else if (im_i_syn) begin
                    beat_d  = beat_q + BW'(1);
                    addr_d  = addr_q + AWIDTH'(4);
                    wcnt_d  = '0;
                    state_d = BEAT_ENTRY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!im_i_syn) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Attributes of the word about to be presented.
    always_comb begin
        rd_idx_c      = addr_d >> 2;
        rd_in_range_c = rd_idx_c < AWIDTH'(DEPTH);
        rd_last_c     = (beat_d == BW'(BURST_LEN - 1)) || (rd_idx_c == AWIDTH'(DEPTH - 1));
        enter_resp_c  = (state_d == S_RESP);
        wr_in_range_c = (im_i_waddr >> 2) < AWIDTH'(DEPTH);
    end

    // State and response registers.
    always_ff @(posedge im_clk or negedge im_rst) begin
        if (!im_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= enter_resp_c;
            last_q  <= enter_resp_c && rd_last_c;
            err_q   <= enter_resp_c && !rd_in_range_c;
            busy_q  <= (state_d != S_IDLE);
            if (enter_resp_c) begin
                instr_q <= rd_in_range_c ? mem[addr_d[IDXW+1:2]] : NOP;
            end
        end
    end

    // Program array: not reset; out-of-range writes are dropped.
    always_ff @(posedge im_clk) begin
        if (im_i_we && wr_in_range_c) begin
            mem[im_i_waddr[IDXW+1:2]] <= im_i_wdata;
        end
    end

    assign im_o_ack   = ack_q;
    assign im_o_last  = last_q;
    assign im_o_err   = err_q;
    assign im_o_busy  = busy_q;
    assign im_o_instr = instr_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: two instances (LATENCY=0 and 1) share
// the request and write inputs; each burst is predicted from the protocol rules
// (word k acked at cycle 1+L+k*(L+1)) and compared cycle by cycle.
module tb_instruction_memory_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BL    = 8;
    localparam logic [31:0] NOPW  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, syn, we;
    logic [31:0] addr, waddr, wdata;
    logic        ack0, last0, err0, busy0;
    logic        ack1, last1, err1, busy1;
    logic [31:0] instr0, instr1;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [DEPTH];
    logic [31:0] held [2];
    int coll_idx;

    always #5 clk = ~clk;

    instruction_memory_responder #(.LATENCY(0)) u_lat0 (
        .im_clk(clk), .im_rst(rst_n), .im_i_syn(syn), .im_i_addr(addr),
        .im_o_ack(ack0), .im_o_last(last0), .im_o_instr(instr0), .im_o_err(err0),
        .im_o_busy(busy0), .im_i_we(we), .im_i_waddr(waddr), .im_i_wdata(wdata)
    );

    instruction_memory_responder #(.LATENCY(1)) u_lat1 (
        .im_clk(clk), .im_rst(rst_n), .im_i_syn(syn), .im_i_addr(addr),
        .im_o_ack(ack1), .im_o_last(last1), .im_o_instr(instr1), .im_o_err(err1),
        .im_o_busy(busy1), .im_i_we(we), .im_i_waddr(waddr), .im_i_wdata(wdata)
    );

    // {ack, last, err, busy, instr} of instance d
    function automatic logic [35:0] obs(input int d);
        if (d == 0) return {ack0, last0, err0, busy0, instr0};
        return {ack1, last1, err1, busy1, instr1};
    endfunction

    task automatic test_reset();
        logic [35:0] o;
        rst_n = 1'b0; syn = 1'b0; we = 1'b0; addr = '0; waddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs(d);
            checks++;
            if (o !== 36'h0) begin
                errors++;
                $display("FAIL reset dut%0d outputs got %h exp %h", d, o, 36'h0);
            end
        end
        rst_n = 1'b1;
        held[0] = '0; held[1] = '0;
    endtask

    task automatic test_load();
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = (32'(i) << 2) | 32'($urandom_range(0, 3));
            wdata = (i < 8) ? 32'h100 + 32'(i) : $urandom;
            mem_model[i] = wdata;
        end
        // Out-of-range writes must not alias onto low indices.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            waddr = (i < 4) ? 32'(DEPTH * 4) + 32'(4 * i) : 32'hFFFF_FFFC;
            wdata = 32'hDEAD_0000 | 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_burst(input string name, input logic [31:0] start, input int drop);
        int          s_cyc, cyc;
        int          last_cyc [2];
        logic        xa [2][64];
        logic        xl [2][64];
        logic        xe [2][64];
        logic [31:0] xi [2][64];
        logic [31:0] a, idx;
        logic [35:0] o;
        logic        xb;
        s_cyc = (drop > 0) ? drop : 20;
        for (int d = 0; d < 2; d++) begin
            last_cyc[d] = -1;
            for (int c = 0; c < 64; c++) begin
                xa[d][c] = 1'b0; xl[d][c] = 1'b0; xe[d][c] = 1'b0; xi[d][c] = '0;
            end
            for (int k = 0; k < int'(BL); k++) begin
                cyc = 1 + d + k * (d + 1);
                if (cyc > s_cyc) break;
                a   = start + 32'(4 * k);
                idx = a >> 2;
                xa[d][cyc] = 1'b1;
                xe[d][cyc] = (idx >= 32'(DEPTH));
                xi[d][cyc] = (idx < 32'(DEPTH)) ? mem_model[idx[9:0]] : NOPW;
                xl[d][cyc] = (k == int'(BL) - 1) || (idx == 32'(DEPTH - 1));
                if (xl[d][cyc]) begin
                    last_cyc[d] = cyc;
                    break;
                end
            end
        end
        @(negedge clk);
        syn  = 1'b1;
        addr = start;
        for (int c = 1; c <= s_cyc + 2; c++) begin
            @(negedge clk);
            addr = $urandom;
            for (int d = 0; d < 2; d++) begin
                o  = obs(d);
                xb = (c <= s_cyc) || (last_cyc[d] == s_cyc && c == s_cyc + 1);
                checks++;
                if (o[35] !== xa[d][c]) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d ack got %b exp %b", name, d, c, o[35], xa[d][c]);
                end
                checks++;
                if (o[32] !== xb) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d busy got %b exp %b", name, d, c, o[32], xb);
                end
                if (xa[d][c]) held[d] = xi[d][c];
                checks++;
                if (o[31:0] !== held[d]) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d instr got %h exp %h", name, d, c, o[31:0], held[d]);
                end
                checks++;
                if (o[34] !== xl[d][c] || o[33] !== xe[d][c]) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d last/err got %b/%b exp %b/%b",
                             name, d, c, o[34], o[33], xl[d][c], xe[d][c]);
                end
            end
            if (c == s_cyc) syn = 1'b0;
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_w, new_w;
        coll_idx = int'($urandom_range(0, DEPTH - 9));
        old_w = mem_model[coll_idx];
        new_w = ~old_w;
        @(negedge clk);
        syn = 1'b1; addr = 32'(coll_idx) << 2;
        we = 1'b1; waddr = 32'(coll_idx) << 2; wdata = new_w;
        @(negedge clk);
        we = 1'b0;
        checks++;
        if (ack0 !== 1'b1 || instr0 !== old_w) begin
            errors++;
            $display("FAIL collision read-first got ack=%b instr=%h exp ack=1 instr=%h", ack0, instr0, old_w);
        end
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || instr1 !== new_w) begin
            errors++;
            $display("FAIL collision later-read got ack=%b instr=%h exp ack=1 instr=%h", ack1, instr1, new_w);
        end
        syn = 1'b0;
        mem_model[coll_idx] = new_w;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic [35:0] o;
        @(negedge clk);
        syn = 1'b1; addr = 32'($urandom_range(0, DEPTH - 9)) << 2;
        repeat (2) @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid precondition got ack=%b busy=%b exp 1/1", ack1, busy1);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            o = obs(d);
            checks++;
            if (o !== 36'h0) begin
                errors++;
                $display("FAIL rst_mid dut%0d outputs got %h exp %h", d, o, 36'h0);
            end
        end
        syn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid idle busy got %b/%b exp 0/0", busy0, busy1);
        end
        held[0] = '0; held[1] = '0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int drop;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
                1: a = 32'(DEPTH - $urandom_range(1, 9)) << 2;
                2: a = 32'(DEPTH + $urandom_range(0, 100)) << 2;
                default: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            drop = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
            test_burst("random", a, drop);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_burst("t1_lat1_addr0", 32'h0, 0);
        test_burst("t2_addr10", 32'h10, 0);
        test_burst("t3_top", 32'((DEPTH - 2) * 4), 0);
        test_burst("t4_oob", 32'(DEPTH * 4), 0);
        test_burst("t5_flush", 32'h0, 7);
        test_burst("t5_restart", 32'h20, 0);
        test_collision();
        test_reset_mid_burst();
        test_burst("t6_reread", 32'(coll_idx) << 2, 0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout reached got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
